// File: rtl/loader_pkg.sv
// Shared constants, state encoding and state-decode helpers for the instruction loader.
// LOADER_CHECKSUM_EN adds the RECV_CSUM state used by the optional checksum trailer.
package loader_pkg;

    localparam int unsigned IM_DEPTH       = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 2;
    localparam int unsigned IM_WORD_W      = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned ADDR_W         = $clog2(IM_DEPTH);
    localparam int unsigned CNT_W          = ADDR_W + 1;

    localparam logic [IM_WORD_W-1:0] HALT_WORD = 16'hFFFF;
    localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(IM_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RECV_HI   = 3'd1,
        RECV_LO   = 3'd2,
        WRITE     = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        RECV_CSUM = 3'd4,
`endif
        DONE      = 3'd5
    } loader_state_e;

    // States in which the loader offers byte_ready to the source.
    function automatic logic takes_bytes(input loader_state_e s);
`ifdef LOADER_CHECKSUM_EN
        return (s == RECV_HI) || (s == RECV_LO) || (s == RECV_CSUM);
`else
        return (s == RECV_HI) || (s == RECV_LO);
`endif
    endfunction

    function automatic logic is_busy(input loader_state_e s);
        return (s != IDLE) && (s != DONE);
    endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input, instruction-memory write port and core-control status of the loader.
interface instruction_loader_if;
    import loader_pkg::*;

    logic                 start;
    logic                 byte_valid;
    logic [BYTE_W-1:0]    byte_data;
    logic                 byte_ready;
    logic                 im_we;
    logic [ADDR_W-1:0]    im_waddr;
    logic [IM_WORD_W-1:0] im_wdata;
    logic                 busy;
    logic                 done;
    logic                 cpu_hold;
    logic [CNT_W-1:0]     word_count;
    logic                 checksum_err;

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, im_we, im_waddr, im_wdata,
        input  busy, done, cpu_hold, word_count, checksum_err
    );

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, im_we, im_waddr, im_wdata,
        output busy, done, cpu_hold, word_count, checksum_err
    );

endinterface

// File: rtl/byte_packer.sv
// Packs two accepted bytes into one instruction word, high byte first.
module byte_packer
    import loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_i,
    input  logic                 byte_en_i,
    input  logic [BYTE_W-1:0]    byte_i,
    output logic [IM_WORD_W-1:0] word_o,
    output logic                 word_ready_c_o
);

    logic                 lo_phase_q;
    logic [IM_WORD_W-1:0] word_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lo_phase_q <= 1'b0;
            word_q     <= '0;
        end else if (clear_i) begin
            lo_phase_q <= 1'b0;
        end else if (byte_en_i) begin
            if (lo_phase_q) begin
                word_q[BYTE_W-1:0] <= byte_i;
            end else begin
                word_q[IM_WORD_W-1:BYTE_W] <= byte_i;
            end
            lo_phase_q <= ~lo_phase_q;
        end
    end

    assign word_o         = word_q;
    // Second byte of the pair is being accepted this cycle.
    assign word_ready_c_o = byte_en_i && lo_phase_q;

endmodule

// File: rtl/instruction_loader.sv
// Fills the instruction memory from a byte stream, holding the core until the load completes.
// LOADER_CHECKSUM_EN adds an XOR checksum trailer byte checked after the final word.
module instruction_loader
    import loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    instruction_loader_if.slave  bus
);

    loader_state_e        state_q, state_d;
    logic [ADDR_W-1:0]    waddr_q, waddr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 ready_q, ready_d;
    logic                 we_q, we_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 hold_q, hold_d;
    logic                 restart_c;
    logic                 xfer_c;
    logic                 pack_en_c;
    logic                 word_ready_c;
    logic [IM_WORD_W-1:0] wdata;

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]    csum_q, csum_d;
    logic                 csum_err_q, csum_err_d;
`endif

    assign xfer_c    = bus.byte_valid && ready_q;
    assign pack_en_c = xfer_c && ((state_q == RECV_HI) || (state_q == RECV_LO));

    byte_packer u_packer (
        .clk            (clk),
        .reset          (reset),
        .clear_i        (restart_c),
        .byte_en_i      (pack_en_c),
        .byte_i         (bus.byte_data),
        .word_o         (wdata),
        .word_ready_c_o (word_ready_c)
    );

    // Next state; outputs are decoded from the next state so they register alongside it.
    always_comb begin
        state_d   = state_q;
        waddr_d   = waddr_q;
        count_d   = count_q;
        restart_c = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        csum_err_d = csum_err_q;
`endif

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = RECV_HI;
                    waddr_d   = '0;
                    count_d   = '0;
                    restart_c = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = '0;
                    csum_err_d = 1'b0;
`endif
                end
            end
            RECV_HI: begin
                if (xfer_c) state_d = RECV_LO;
            end
            RECV_LO: begin
                if (word_ready_c) state_d = WRITE;
            end
            WRITE: begin
                count_d = count_q + CNT_W'(1);
                if ((wdata == HALT_WORD) || (waddr_q == LAST_ADDR)) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = RECV_CSUM;
`else
                    state_d = DONE;
`endif
                end else begin
                    waddr_d = waddr_q + ADDR_W'(1);
                    state_d = RECV_HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            RECV_CSUM: begin
                if (xfer_c) begin
                    if (bus.byte_data != csum_q) csum_err_d = 1'b1;
                    state_d = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

`ifdef LOADER_CHECKSUM_EN
        if (pack_en_c) csum_d = csum_q ^ bus.byte_data;
`endif

        ready_d = takes_bytes(state_d);
        we_d    = (state_d == WRITE);
        busy_d  = is_busy(state_d);
        done_d  = (state_d == DONE);
        hold_d  = (state_d != DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            waddr_q <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            count_q <= count_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q     <= '0;
            csum_err_q <= 1'b0;
        end else begin
            csum_q     <= csum_d;
            csum_err_q <= csum_err_d;
        end
    end

    assign bus.checksum_err = csum_err_q;
`else
    assign bus.checksum_err = 1'b0;
`endif

    assign bus.byte_ready = ready_q;
    assign bus.im_we      = we_q;
    assign bus.im_waddr   = waddr_q;
    assign bus.im_wdata   = wdata;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.word_count = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader; write-port activity is logged at each rising edge.
module tb_instruction_loader;
    import loader_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [BYTE_W-1:0]    tb_xor;
    logic [ADDR_W-1:0]    wr_addr[$];
    logic [IM_WORD_W-1:0] wr_data[$];

    always #5 clk = ~clk;

    instruction_loader_if bus();

    instruction_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clk) begin
        if (bus.im_we) begin
            wr_addr.push_back(bus.im_waddr);
            wr_data.push_back(bus.im_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_write(input int idx, input logic [ADDR_W-1:0] a, input logic [IM_WORD_W-1:0] d);
        if (idx < wr_addr.size()) begin
            check($sformatf("wr_addr[%0d]", idx), 32'(wr_addr[idx]), 32'(a));
            check($sformatf("wr_data[%0d]", idx), 32'(wr_data[idx]), 32'(d));
        end else begin
            check($sformatf("wr_present[%0d]", idx), 32'(wr_addr.size()), 32'(idx + 1));
        end
    endtask

    // Offer a byte after 'gap' idle cycles; returns on the falling edge after it is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bus.byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        n = 0;
        while (!bus.byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.byte_ready) check("byte_accept", 32'(bus.byte_ready), 32'd1);
        @(negedge clk);
        tb_xor = tb_xor ^ b;
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input int gap_hi, input int gap_lo);
        send_byte(w[15:8], gap_hi);
        send_byte(w[7:0], gap_lo);
    endtask

    task automatic pulse_start();
        wr_addr.delete();
        wr_data.delete();
        tb_xor = '0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // From the final WRITE cycle to DONE (via the checksum trailer when compiled in).
    task automatic close_load();
`ifdef LOADER_CHECKSUM_EN
        send_byte(tb_xor, 0);
`else
        @(negedge clk);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        tb_xor         = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_im_we", 32'(bus.im_we), 32'd0);
        check("rst_im_waddr", 32'(bus.im_waddr), 32'd0);
        check("rst_im_wdata", 32'(bus.im_wdata), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check("rst_word_count", 32'(bus.word_count), 32'd0);
        check("rst_checksum_err", 32'(bus.checksum_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_byte_ready", 32'(bus.byte_ready), 32'd0);

        // Short program ending in the halt word
        pulse_start();
        check("s1_busy", 32'(bus.busy), 32'd1);
        check("s1_byte_ready", 32'(bus.byte_ready), 32'd1);
        send_word(16'h0004, 0, 0);
        send_word(16'h0005, 0, 0);
        send_word(16'hFFFF, 0, 0);
        check("s1_we_last", 32'(bus.im_we), 32'd1);
        check("s1_waddr_last", 32'(bus.im_waddr), 32'd2);
        check("s1_wdata_last", 32'(bus.im_wdata), 32'hFFFF);
        check("s1_hold_in_write", 32'(bus.cpu_hold), 32'd1);
        check("s1_done_in_write", 32'(bus.done), 32'd0);
        close_load();
        check("s1_done", 32'(bus.done), 32'd1);
        check("s1_cpu_hold", 32'(bus.cpu_hold), 32'd0);
        check("s1_busy_done", 32'(bus.busy), 32'd0);
        check("s1_word_count", 32'(bus.word_count), 32'd3);
        check("s1_checksum_err", 32'(bus.checksum_err), 32'd0);
        check("s1_nwrites", 32'(wr_addr.size()), 32'd3);
        check_write(0, 5'd0, 16'h0004);
        check_write(1, 5'd1, 16'h0005);
        check_write(2, 5'd2, 16'hFFFF);
        repeat (3) @(negedge clk);
        check("s1_done_held", 32'(bus.done), 32'd1);

        // Full memory, no halt word
        pulse_start();
        for (int i = 0; i < IM_DEPTH; i++) begin
            send_word({8'(i), 8'(8'hA0 + i)}, 0, 0);
        end
        close_load();
        check("s2_done", 32'(bus.done), 32'd1);
        check("s2_word_count", 32'(bus.word_count), 32'd32);
        check("s2_nwrites", 32'(wr_addr.size()), 32'd32);
        for (int i = 0; i < IM_DEPTH; i++) begin
            check_write(i, 5'(i), {8'(i), 8'(8'hA0 + i)});
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h5A;
        repeat (3) @(negedge clk);
        check("s2_extra_ready", 32'(bus.byte_ready), 32'd0);
        check("s2_extra_nwrites", 32'(wr_addr.size()), 32'd32);
        check("s2_waddr_nowrap", 32'(bus.im_waddr), 32'd31);
        check("s2_count_hold", 32'(bus.word_count), 32'd32);
        bus.byte_valid = 1'b0;

        // Gaps on byte_valid
        pulse_start();
        send_word(16'h1234, $urandom_range(0, 4), $urandom_range(0, 4));
        send_word(16'hABCD, $urandom_range(0, 4), $urandom_range(0, 4));
        send_word(16'hFFFF, $urandom_range(0, 4), $urandom_range(0, 4));
        close_load();
        check("s3_nwrites", 32'(wr_addr.size()), 32'd3);
        check_write(0, 5'd0, 16'h1234);
        check_write(1, 5'd1, 16'hABCD);
        check_write(2, 5'd2, 16'hFFFF);
        check("s3_word_count", 32'(bus.word_count), 32'd3);

        // Reset after the high byte of word 1
        pulse_start();
        send_word(16'h5566, 0, 0);
        send_byte(8'h77, 0);
        reset = 1'b1;
        @(negedge clk);
        check("s4_we", 32'(bus.im_we), 32'd0);
        check("s4_busy", 32'(bus.busy), 32'd0);
        check("s4_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("s4_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check("s4_word_count", 32'(bus.word_count), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("s4_nwrites", 32'(wr_addr.size()), 32'd1);
        check_write(0, 5'd0, 16'h5566);
        pulse_start();
        send_word(16'h1122, 0, 0);
        send_word(16'hFFFF, 0, 0);
        close_load();
        check("s4_reload_nwrites", 32'(wr_addr.size()), 32'd2);
        check_write(0, 5'd0, 16'h1122);
        check_write(1, 5'd1, 16'hFFFF);
        check("s4_reload_count", 32'(bus.word_count), 32'd2);

        // start asserted during RECV_LO and WRITE
        pulse_start();
        send_byte(8'hAB, 0);
        bus.start = 1'b1;
        send_byte(8'hCD, 0);
        check("s5_we_with_start", 32'(bus.im_we), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        send_word(16'hFFFF, 0, 0);
        close_load();
        check("s5_nwrites", 32'(wr_addr.size()), 32'd2);
        check_write(0, 5'd0, 16'hABCD);
        check_write(1, 5'd1, 16'hFFFF);
        check("s5_word_count", 32'(bus.word_count), 32'd2);
        check("s5_done", 32'(bus.done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Checksum trailer: 12^34^FF^FF = 26
        pulse_start();
        send_word(16'h1234, 0, 0);
        send_word(16'hFFFF, 0, 0);
        send_byte(8'h26, 0);
        check("c1_done", 32'(bus.done), 32'd1);
        check("c1_checksum_err", 32'(bus.checksum_err), 32'd0);
        pulse_start();
        send_word(16'h1234, 0, 0);
        send_word(16'hFFFF, 0, 0);
        send_byte(8'h27, 0);
        check("c2_done", 32'(bus.done), 32'd1);
        check("c2_checksum_err", 32'(bus.checksum_err), 32'd1);
        repeat (2) @(negedge clk);
        check("c2_err_held", 32'(bus.checksum_err), 32'd1);
        pulse_start();
        check("c2_err_cleared", 32'(bus.checksum_err), 32'd0);
        check("c2_restart_busy", 32'(bus.busy), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Write-side companion to the 32x16 instruction memory: fills it from a byte stream before the single-cycle core runs.
- Accepts bytes over a valid/ready handshake and packs each pair into a 16-bit instruction, high byte first.
- Drives the memory's write port with sequential addresses and holds the core while loading.
- Stops after the halt word (16'hFFFF) or after the last address.

Parameters:
- DEPTH, 32, number of instruction words; load wraps never, ends at DEPTH-1
- ADDR_W, 5, write address width ($clog2(DEPTH))
- HALT_WORD, 16'hFFFF, instruction word that terminates a load early (the halt opcode 111 with all-ones field)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, begins a load from address 0
- byte_valid  in  1  source has a byte on byte_data
- byte_data  in  8  incoming byte
- byte_ready  out  1  loader can accept a byte this cycle
- im_we  out  1  instruction memory write enable, one-cycle pulse per word
- im_waddr  out  ADDR_W  write address
- im_wdata  out  16  packed instruction word
- busy  out  1  load in progress
- done  out  1  load finished, held until next start or reset
- cpu_hold  out  1  keeps the core in reset/stall; high in every state except DONE
- word_count  out  ADDR_W+1  number of words written in the current load
- checksum_err  out  1  checksum mismatch (see Optional Feature)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - state=IDLE
  - byte_ready=0, im_we=0, im_waddr=0, im_wdata=0
  - busy=0, done=0, cpu_hold=1, word_count=0, checksum_err=0
- Byte transfer occurs in a cycle where byte_valid && byte_ready. byte_data is ignored in all other cycles.
- FSM states: IDLE, RECV_HI, RECV_LO, WRITE, (RECV_CSUM), DONE.
  - IDLE: byte_ready=0. start -> RECV_HI; clears im_waddr, word_count, checksum accumulator and checksum_err.
  - RECV_HI: byte_ready=1. On transfer, latch byte into im_wdata[15:8] -> RECV_LO.
  - RECV_LO: byte_ready=1. On transfer, latch byte into im_wdata[7:0] -> WRITE.
  - WRITE: im_we=1 for exactly this cycle with stable im_waddr/im_wdata; byte_ready=0; word_count increments.
    - If im_wdata==HALT_WORD or im_waddr==DEPTH-1: go to DONE (RECV_CSUM when the feature is compiled in).
    - Otherwise im_waddr increments and the FSM returns to RECV_HI.
  - DONE: done=1, cpu_hold=0, byte_ready=0. start -> restart as from IDLE. Bytes offered in DONE are not accepted.
- Latency: minimum 3 cycles per word (HI, LO, WRITE). byte_valid stalls extend HI/LO indefinitely.
- busy=1 in RECV_HI, RECV_LO, WRITE and RECV_CSUM.
- start while busy is ignored.
- Reset mid-load returns to IDLE next edge with im_we=0. Memory words already written are left as written, with no clearing pass.
- Words beyond the halt word keep their previous contents.
- word_count is at most DEPTH (6 bits for DEPTH=32). im_waddr never wraps.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - The loader keeps an 8-bit running XOR of every accepted data byte.
  - After the final WRITE it enters RECV_CSUM (byte_ready=1) and accepts one checksum byte.
  - If that byte != the XOR, checksum_err=1, held through DONE until start/reset.
  - DONE is entered after the checksum byte either way.
- Undefined: there is no RECV_CSUM state and no accumulator; checksum_err is tied to 0.

Decomposition:
- Shared package loader_pkg holds the state enum (loader_state_e), HALT_WORD, the IM_DEPTH=32 and IM_WORD_W=16 constants, and BYTES_PER_WORD=2.
- One natural sub-module: byte_packer (shift-in of two bytes plus a word-ready strobe), instantiated once. All other logic lives in the top FSM.

Test Plan:
- Reset released, start, stream 00 04 00 05 FF FF with byte_valid always high. Expected:
  - writes addr0=0x0004, addr1=0x0005, addr2=0xFFFF
  - done next cycle, word_count=3, cpu_hold falls with done
- Stream 64 bytes with no halt word. Expected: 32 writes at addrs 0..31, DONE after addr31, word_count=32; a 65th byte is not accepted (byte_ready=0).
- Random byte_valid gaps on 3 words. Expected: im_we fires exactly once per word, with correct data and addresses, regardless of gaps.
- Assert reset after the high byte of word 1. Expected: IDLE next edge, im_we never pulses for word 1, addr0 keeps its data; a new start reloads from addr0.
- start pulses during RECV_LO and during WRITE. Expected: ignored; sequence and addresses unchanged.
- With LOADER_CHECKSUM_EN, stream 12 34 FF FF then checksum byte 26. Expected: checksum_err=0.
- Same stream with checksum byte 27. Expected: checksum_err=1 in DONE, cleared by the next start.
